// File: rtl/voting_pkg.sv
// Shared types and helpers for the parametrised voting machine.
package voting_pkg;

  // Widest button vector the helpers accept (NUM_CAND tops out at 16).
  localparam int MAX_CAND = 16;

  // Press-detector FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic int lowest_idx(input logic [MAX_CAND-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_CAND - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_one_hot(input logic [MAX_CAND-1:0] v);
    return (v != '0) && ((v & (v - MAX_CAND'(1))) == '0);
  endfunction

  // Increment that sticks at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == maxv) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/vote_press_detector.sv
// Turns held one-hot button presses into single accept pulses.
// A press must be stable for HOLD_CYCLES samples; anything ambiguous
// parks the FSM in WAIT_REL until every button is released.
module vote_press_detector
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [NUM_CAND-1:0]         button,
  output logic                        accept,
  output logic [$clog2(NUM_CAND)-1:0] accept_idx,
  output state_t                      state
);

  localparam int IDX_W  = $clog2(NUM_CAND);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   idx;
  logic               qual;
  // Cleared by reset; set once an all-released sample is seen, so a button
  // still held across reset cannot start a press.
  logic               released_q;

  assign state = state_q;

  // State, hold count, selected candidate and release tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      sel_q      <= '0;
      released_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      if (button == '0) released_q <= 1'b1;
    end
  end

  // Next-state, hold counting and accept generation.
  always_comb begin
    idx        = IDX_W'(lowest_idx(MAX_CAND'(button)));
    qual       = !mode && is_one_hot(MAX_CAND'(button));
    state_d    = state_q;
    hold_d     = hold_q;
    sel_d      = sel_q;
    accept     = 1'b0;
    accept_idx = sel_q;
    case (state_q)
      IDLE: begin
        if (qual && released_q) begin
          sel_d      = idx;
          hold_d     = HOLD_W'(1);
          accept_idx = idx;
          if (HOLD_CYCLES == 1) begin
            accept  = 1'b1;
            state_d = WAIT_REL;
          end else begin
            state_d = ARM;
          end
        end else if (!mode && button != '0) begin
          state_d = WAIT_REL;
        end
      end
      ARM: begin
        if (button == '0) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (qual && idx == sel_q) begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_d == HOLD_MAX) begin
            accept  = 1'b1;
            state_d = WAIT_REL;
          end
        end else begin
          // Different button, several buttons, or display mode: abandon.
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (button == '0) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/voting_machine_n.sv
// N-candidate voting machine: press qualification, saturating counters,
// display readback and registered leader/tie reduction.
// vote_valid pulses for one cycle per accepted vote; there is no
// back-pressure, so each pulse must be consumed in the cycle it appears.
module voting_machine_n
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 10,
  parameter int TOT_W       = CNT_W + $clog2(NUM_CAND)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [NUM_CAND-1:0]         button,
  output logic [CNT_W-1:0]            leds,
  output logic                        vote_valid,
  output logic [$clog2(NUM_CAND)-1:0] vote_idx,
  output logic [$clog2(NUM_CAND)-1:0] leader,
  output logic                        tie,
  output logic [TOT_W-1:0]            total_votes,
  output state_t                      fsm_state
);

  localparam int IDX_W = $clog2(NUM_CAND);

  logic             accept;
  logic [IDX_W-1:0] accept_idx;
  logic [CNT_W-1:0] count_q [NUM_CAND];
  logic [IDX_W-1:0] disp_idx;
  logic [CNT_W-1:0] max_cnt;
  logic [IDX_W-1:0] best_idx;
  int               n_max;
  logic             tie_d;

  vote_press_detector #(
    .NUM_CAND   (NUM_CAND),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_press (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .button    (button),
    .accept    (accept),
    .accept_idx(accept_idx),
    .state     (fsm_state)
  );

  // Per-candidate and total counters plus the accept pulse/index.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) count_q[i] <= '0;
      total_votes <= '0;
      vote_valid  <= 1'b0;
      vote_idx    <= '0;
    end else begin
      vote_valid <= accept;
      if (accept) begin
        vote_idx            <= accept_idx;
        count_q[accept_idx] <= CNT_W'(sat_inc(32'(count_q[accept_idx]), CNT_W));
        total_votes         <= TOT_W'(sat_inc(32'(total_votes), TOT_W));
      end
    end
  end

  // Display readback of the lowest pressed candidate; dark in vote mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      leds <= '0;
    end else if (mode && button != '0) begin
      leds <= count_q[disp_idx];
    end else begin
      leds <= '0;
    end
  end

  // Maximum count, first index holding it, and whether it is shared.
  always_comb begin
    disp_idx = IDX_W'(lowest_idx(MAX_CAND'(button)));
    max_cnt  = '0;
    best_idx = '0;
    n_max    = 0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (count_q[i] > max_cnt) begin
        max_cnt  = count_q[i];
        best_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (count_q[i] == max_cnt) n_max = n_max + 1;
    end
    tie_d = (max_cnt != '0) && (n_max >= 2);
  end

  // Registered leader/tie, one cycle behind the counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      leader <= '0;
      tie    <= 1'b0;
    end else begin
      leader <= best_idx;
      tie    <= tie_d;
    end
  end

endmodule

// File: tb/tb_voting_machine_n.sv
// Directed bench for voting_machine_n (4 candidates, 8-bit counts, hold 10).
module tb_voting_machine_n;
  import voting_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic [3:0] button;
  logic [7:0] leds;
  logic       vote_valid;
  logic [1:0] vote_idx;
  logic [1:0] leader;
  logic       tie;
  logic [9:0] total_votes;
  state_t     fsm_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    int mode;
    int button;
    int cycles;
    int pulse_at;
    int idx;
    int leds;
    int leader;
    int tie;
    int total;
  } seg_t;

  seg_t tbl [32];

  // Clock
  always #5 clock = ~clock;

  voting_machine_n #(
    .NUM_CAND   (4),
    .CNT_W      (8),
    .HOLD_CYCLES(10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .button     (button),
    .leds       (leds),
    .vote_valid (vote_valid),
    .vote_idx   (vote_idx),
    .leader     (leader),
    .tie        (tie),
    .total_votes(total_votes),
    .fsm_state  (fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; sample 1 ns after the edge and score any vote pulse.
  task automatic tick();
    logic [1:0] e;
    @(posedge clock);
    #1;
    if (vote_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL vote_unexpected: got vote idx %0d expected no vote at %0t", vote_idx, $time);
      end else begin
        e = exp_q.pop_front();
        check("vote_idx", 32'(vote_idx), 32'(e));
      end
    end
  endtask

  function automatic seg_t mk(int m, int b, int n, int p, int ix, int l, int ld, int t, int tot);
    seg_t s;
    s.mode = m; s.button = b; s.cycles = n; s.pulse_at = p; s.idx = ix;
    s.leds = l; s.leader = ld; s.tie = t; s.total = tot;
    return s;
  endfunction

  // Hold one input pattern for s.cycles clocks, checking the pulse timing
  // every cycle and the registered outputs at the end.
  task automatic run_seg(input int id, input seg_t s);
    mode   = s.mode[0];
    button = s.button[3:0];
    if (s.pulse_at > 0) exp_q.push_back(s.idx[1:0]);
    for (int c = 1; c <= s.cycles; c++) begin
      tick();
      check($sformatf("seg%0d_valid_c%0d", id, c), 32'(vote_valid), 32'(c == s.pulse_at));
    end
    check($sformatf("seg%0d_leds", id), 32'(leds), s.leds);
    check($sformatf("seg%0d_leader", id), 32'(leader), s.leader);
    check($sformatf("seg%0d_tie", id), 32'(tie), s.tie);
    check($sformatf("seg%0d_total", id), 32'(total_votes), s.total);
  endtask

  initial begin
    //                mode btn  cyc pulse idx leds ld tie total
    tbl[0]  = mk(0, 'h1, 20, 10, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 'h0,  1,  0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 'h2,  5,  0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 'h0,  1,  0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 'h2,  3,  0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 'h0,  1,  0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 'h6, 20,  0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 'h2,  2,  0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 'h1,  1,  0, 0, 1, 0, 0, 1);
    tbl[9]  = mk(1, 'h0,  1,  0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 'h0,  1,  0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 'h4, 10, 10, 2, 0, 0, 0, 2);
    tbl[12] = mk(0, 'h0,  1,  0, 0, 0, 0, 1, 2);
    tbl[13] = mk(0, 'h4, 10, 10, 2, 0, 0, 1, 3);
    tbl[14] = mk(0, 'h0,  1,  0, 0, 0, 2, 0, 3);
    tbl[15] = mk(0, 'h8, 10, 10, 3, 0, 2, 0, 4);
    tbl[16] = mk(0, 'h0,  1,  0, 0, 0, 2, 0, 4);
    tbl[17] = mk(0, 'h8, 10, 10, 3, 0, 2, 0, 5);
    tbl[18] = mk(0, 'h0,  1,  0, 0, 0, 2, 1, 5);
    tbl[19] = mk(0, 'h8, 10, 10, 3, 0, 2, 1, 6);
    tbl[20] = mk(0, 'h0,  1,  0, 0, 0, 3, 0, 6);
    tbl[21] = mk(1, 'h4,  1,  0, 0, 2, 3, 0, 6);
    tbl[22] = mk(1, 'h8,  1,  0, 0, 3, 3, 0, 6);
    tbl[23] = mk(1, 'hC,  1,  0, 0, 2, 3, 0, 6);
    tbl[24] = mk(1, 'h0,  1,  0, 0, 0, 3, 0, 6);
    tbl[25] = mk(0, 'h1,  5,  0, 0, 0, 3, 0, 6);
    tbl[26] = mk(1, 'h1,  1,  0, 0, 1, 3, 0, 6);
    tbl[27] = mk(0, 'h1, 10,  0, 0, 0, 3, 0, 6);
    tbl[28] = mk(0, 'h0,  1,  0, 0, 0, 3, 0, 6);
    tbl[29] = mk(0, 'h1,  4,  0, 0, 0, 3, 0, 6);
    tbl[30] = mk(0, 'h2, 10,  0, 0, 0, 3, 0, 6);
    tbl[31] = mk(0, 'h0,  1,  0, 0, 0, 3, 0, 6);

    // Reset block
    reset  = 1'b1;
    mode   = 1'b0;
    button = 4'b0000;
    repeat (10) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("rst_leds", 32'(leds), 0);
    check("rst_valid", 32'(vote_valid), 0);
    check("rst_vote_idx", 32'(vote_idx), 0);
    check("rst_leader", 32'(leader), 0);
    check("rst_tie", 32'(tie), 0);
    check("rst_total", 32'(total_votes), 0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));

    // Table-driven main function
    for (int i = 0; i < 32; i++) run_seg(i, tbl[i]);

    // Saturation: 260 more votes for candidate 0 on top of count0=1.
    for (int k = 1; k <= 260; k++) begin
      mode   = 1'b0;
      button = 4'b0001;
      exp_q.push_back(2'd0);
      for (int c = 1; c <= 10; c++) begin
        tick();
        check($sformatf("sat%0d_valid_c%0d", k, c), 32'(vote_valid), 32'(c == 10));
      end
      button = 4'b0000;
      tick();
    end
    check("sat_total", 32'(total_votes), 266);
    check("sat_leader", 32'(leader), 0);
    check("sat_tie", 32'(tie), 0);
    mode   = 1'b1;
    button = 4'b0001;
    tick();
    check("sat_leds", 32'(leds), 255);

    // Reset in the middle of an ARM sequence with the button held.
    mode   = 1'b0;
    button = 4'b0000;
    tick();
    button = 4'b0010;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("rarm_valid_c%0d", c), 32'(vote_valid), 0);
    end
    check("rarm_state", 32'(fsm_state), 32'(ARM));
    reset = 1'b1;
    repeat (2) tick();
    check("rmid_leds", 32'(leds), 0);
    check("rmid_valid", 32'(vote_valid), 0);
    check("rmid_leader", 32'(leader), 0);
    check("rmid_tie", 32'(tie), 0);
    check("rmid_total", 32'(total_votes), 0);
    check("rmid_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check($sformatf("rheld_valid_c%0d", c), 32'(vote_valid), 0);
    end
    check("rheld_state", 32'(fsm_state), 32'(WAIT_REL));
    check("rheld_total", 32'(total_votes), 0);
    button = 4'b0000;
    tick();
    check("rdrop_state", 32'(fsm_state), 32'(IDLE));
    run_seg(100, mk(0, 'h2, 10, 10, 1, 0, 0, 0, 1));
    run_seg(101, mk(0, 'h0,  1,  0, 0, 0, 1, 0, 1));
    run_seg(102, mk(1, 'h2,  1,  0, 0, 1, 1, 0, 1));

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
